uart_host: RTL and testbench
============================

Name: uart_host

Overview:
- Host-side endpoint of the processor's serial link: the far end of the UART wire from the on-FPGA processor wrapper.
- Accepts INP_WIDTH-bit AXI-Stream words, splits each into bytes, and transmits them over 8N1 UART.
- Receives 8N1 bytes, reassembles them into OUT_WIDTH-bit words, and presents them on an AXI-Stream master.
- Used for board-to-board links, on-chip self-test, and loopback benches against the processor wrapper.

Parameters:
- INP_WIDTH, 16, width of words sent to the processor; multiple of 8, else elaboration error.
- OUT_WIDTH, 24, width of words received from the processor; multiple of 8, else elaboration error.

Ports:
- clk  input  1  clock
- arstn  input  1  reset, asynchronous, active-low
- s_axis_tdata  input  INP_WIDTH  word to transmit
- s_axis_tvalid  input  1  transmit word valid
- s_axis_tready  output  1  transmitter accepts a word
- m_axis_tdata  output  OUT_WIDTH  received word
- m_axis_tvalid  output  1  received word valid
- m_axis_tready  input  1  consumer accepts the received word
- rxd  input  1  UART serial in, idle high
- txd  output  1  UART serial out, idle high
- prescale  input  16  bit time = 8*prescale clk cycles; 0 is treated as 1; sampled at each start bit
- tx_busy  output  1  transmitter mid-word
- rx_busy  output  1  receiver mid-byte
- rx_error  output  1  sticky error flag; cleared only by reset

Behaviour:
- Reset values: txd=1, s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, tx_busy=0, rx_busy=0, rx_error=0. All state returns to IDLE.
- Reset mid-operation aborts any byte in flight; txd goes high immediately.

Byte order and framing:
- Little-endian: byte 0 = tdata[7:0], sent or received first.
- NB_TX = INP_WIDTH/8 bytes per transmitted word; NB_RX = OUT_WIDTH/8 bytes per received word.

TX FSM (IDLE, START, DATA, STOP):
- s_axis_tready=1 only in IDLE. Handshake when tvalid and tready are both high: latch word, byte_idx=0, go to START, tready falls next cycle, tx_busy=1.
- START: txd=0 for one bit time.
- DATA: 8 bits LSB-first, one bit time each.
- STOP: txd=1 for one bit time. If byte_idx<NB_TX-1: increment byte_idx and go to START with no idle gap. Else go to IDLE; tready=1 and tx_busy=0 on the cycle the stop bit ends.
- Word duration: NB_TX*10*8*prescale cycles.
- s_axis_tdata changes while busy are ignored.

RX path:
- rxd passes through a 2-flop synchronizer, reset to 1.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE: a high-to-low transition goes to START; rx_busy=1.
- START: wait 4*prescale cycles, then resample. If high, treat as a false start: back to IDLE, rx_busy=0, no error. If low, go to DATA.
- DATA: sample 8 bits at mid-bit, spaced 8*prescale cycles apart, LSB-first.
- STOP: sample once. rx_busy falls the cycle after the stop sample.
  - Stop=1: shift the byte into the assembly register at position rx_idx. If rx_idx=NB_RX-1, the word is complete; otherwise rx_idx++.
  - Stop=0: frame error. Byte discarded, partial word discarded, rx_idx=0, rx_error=1.
- Word complete:
  - If m_axis_tvalid=0, or m_axis_tready=1 on that cycle: load the output register and set tvalid=1 on the next cycle.
  - Otherwise overrun: the new word is dropped, the held word is kept unchanged, rx_error=1.
  - rx_idx=0 in either case.
- m_axis_tdata is stable while tvalid=1 and tready=0. tvalid falls after the handshake unless a new word loads on the same cycle.
- TX and RX are fully independent; simultaneous activity is supported.

Optional Feature:
- Macro: UART_HOST_RX_TIMEOUT_EN.
- Defined: a counter starts after each accepted byte that leaves a partial word (rx_idx>0). If 32 bit times (256*prescale cycles) pass with no new start bit, the partial word is discarded, rx_idx=0, and rx_error=1. A start bit arriving clears the counter.
- Undefined: no counter is built, and a partial word persists indefinitely.

Test Plan:
- prescale=2, send s_axis_tdata=0xA55A -> txd carries 0x5A then 0xA5, LSB-first. Each bit lasts 16 cycles, frames are back-to-back, and the word takes 320 cycles. tready is low throughout and high when the last stop bit ends.
- prescale=2, bench drives bytes 0x01, 0x02, 0x03 on rxd with m_axis_tready=1 -> m_axis_tdata=0x030201, tvalid high for 1 cycle, rx_error=0.
- Byte 0x11 with stop=0, then 0xAA, 0xBB, 0xCC -> rx_error=1, the partial word is discarded, and the output word is 0xCCBBAA.
- m_axis_tready=0, bench sends words 0x030201 then 0x060504 -> 0x030201 is held, 0x060504 is dropped, rx_error=1. Raising tready yields exactly one handshake.
- rxd low for 3 cycles with prescale=2 (less than the 8-cycle half bit) -> rx_busy pulses, no byte is received, rx_error stays 0.
- Reset asserted mid-transmit at bit 5 of byte 0 -> txd=1 and s_axis_tready=1 immediately. After release, a new word transmits correctly from its start bit.

Source files
------------

// File: rtl/uart_host.sv
// uart_host: host-side endpoint of the processor serial link.
//
// Takes INP_WIDTH-bit AXI-Stream words, splits them into bytes (LSB byte first) and sends each
// byte as an 8N1 UART frame on txd. Receives 8N1 frames on rxd, assembles OUT_WIDTH-bit words
// (first byte received lands in bits [7:0]) and presents them on an AXI-Stream master.
//
// Ports:
//   clk, arstn        clock; asynchronous active-low reset
//   s_axis_t*         word-to-transmit slave (tready high only while the transmitter is idle)
//   m_axis_t*         received-word master (held stable until accepted)
//   rxd / txd         UART serial in / out, both idle high
//   prescale          bit time = 8*prescale clk cycles (0 behaves as 1); latched at each start bit
//   tx_busy / rx_busy transmitter mid-word / receiver mid-byte
//   rx_error          sticky: frame error, overrun or partial-word timeout; cleared by reset only
//
// Build option:
//   UART_HOST_RX_TIMEOUT_EN  when defined, a partial receive word is discarded (and rx_error set)
//                            if 32 bit times pass after an accepted byte without a new start bit.

module uart_host #(
    parameter int unsigned INP_WIDTH = 16,
    parameter int unsigned OUT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic [INP_WIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    input  logic                 rxd,
    output logic                 txd,
    input  logic [15:0]          prescale,
    output logic                 tx_busy,
    output logic                 rx_busy,
    output logic                 rx_error
);

    localparam int unsigned NB_TX = INP_WIDTH / 8;
    localparam int unsigned NB_RX = OUT_WIDTH / 8;
    localparam int unsigned TXIW  = (NB_TX > 1) ? $clog2(NB_TX) : 1;
    localparam int unsigned RXIW  = (NB_RX > 1) ? $clog2(NB_RX) : 1;

    if ((INP_WIDTH % 8) != 0 || INP_WIDTH == 0) begin : g_bad_inp_width
        $error("uart_host: INP_WIDTH must be a non-zero multiple of 8");
    end
    if ((OUT_WIDTH % 8) != 0 || OUT_WIDTH == 0) begin : g_bad_out_width
        $error("uart_host: OUT_WIDTH must be a non-zero multiple of 8");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [15:0] ps_eff;
    logic [18:0] half_m1;

    assign ps_eff  = (prescale == 16'd0) ? 16'd1 : prescale;
    assign half_m1 = {1'b0, ps_eff, 2'b00} - 19'd1;

    // ------------------------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------------------------
    logic [1:0]           tx_state;
    logic [INP_WIDTH-1:0] tx_data;   // shifts right one bit per data bit; next byte ends up low
    logic [TXIW-1:0]      tx_byte;
    logic [2:0]           tx_bit;
    logic [15:0]          tx_ps;
    logic [18:0]          tx_cnt;
    logic [18:0]          tx_bit_m1;

    assign tx_bit_m1 = {tx_ps, 3'b000} - 19'd1;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            tx_state <= ST_IDLE;
            tx_data  <= '0;
            tx_byte  <= '0;
            tx_bit   <= 3'd0;
            tx_ps    <= 16'd1;
            tx_cnt   <= 19'd0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        tx_data  <= s_axis_tdata;
                        tx_byte  <= '0;
                        tx_ps    <= ps_eff;
                        tx_cnt   <= {ps_eff, 3'b000} - 19'd1;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == 19'd0) begin
                        tx_cnt   <= tx_bit_m1;
                        tx_bit   <= 3'd0;
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 19'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == 19'd0) begin
                        tx_cnt  <= tx_bit_m1;
                        tx_data <= tx_data >> 1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 19'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == 19'd0) begin
                        if (tx_byte != TXIW'(NB_TX - 1)) begin
                            // Next byte follows immediately; prescale re-sampled per start bit.
                            tx_byte  <= tx_byte + TXIW'(1);
                            tx_ps    <= ps_eff;
                            tx_cnt   <= {ps_eff, 3'b000} - 19'd1;
                            tx_state <= ST_START;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 19'd1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // Decoded straight from state so reset forces the line high without waiting for a clock.
    always_comb begin
        txd = 1'b1;
        if (tx_state == ST_START) begin
            txd = 1'b0;
        end else if (tx_state == ST_DATA) begin
            txd = tx_data[0];
        end
    end

    assign s_axis_tready = (tx_state == ST_IDLE);
    assign tx_busy       = (tx_state != ST_IDLE);

    // ------------------------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------------------------
    logic [1:0]           rx_sync;
    logic                 rxd_s;
    logic                 rxd_prev;
    logic                 rx_fall;
    logic [1:0]           rx_state;
    logic [15:0]          rx_ps;
    logic [18:0]          rx_cnt;
    logic [18:0]          rx_bit_m1;
    logic [2:0]           rx_bit;
    logic [7:0]           rx_shift;
    logic [RXIW-1:0]      rx_idx;
    logic [OUT_WIDTH-1:0] rx_asm;
    logic [OUT_WIDTH-1:0] asm_next;
    logic [OUT_WIDTH-1:0] m_tdata_q;
    logic                 m_tvalid_q;
    logic                 rx_error_q;

`ifdef UART_HOST_RX_TIMEOUT_EN
    logic        to_run;
    logic [23:0] to_cnt;
    logic [23:0] to_lim_m1;

    assign to_lim_m1 = {rx_ps, 8'h00} - 24'd1;
`endif

    assign rxd_s     = rx_sync[1];
    assign rx_fall   = rxd_prev & ~rxd_s;
    assign rx_bit_m1 = {rx_ps, 3'b000} - 19'd1;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rx_sync  <= 2'b11;
            rxd_prev <= 1'b1;
        end else begin
            rx_sync  <= {rx_sync[0], rxd};
            rxd_prev <= rxd_s;
        end
    end

    // Assembly register with the just-received byte dropped into slot rx_idx.
    always_comb begin
        asm_next = rx_asm;
        for (int i = 0; i < int'(NB_RX); i++) begin
            if (rx_idx == RXIW'(i)) begin
                asm_next[i*8 +: 8] = rx_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rx_state   <= ST_IDLE;
            rx_ps      <= 16'd1;
            rx_cnt     <= 19'd0;
            rx_bit     <= 3'd0;
            rx_shift   <= 8'd0;
            rx_idx     <= '0;
            rx_asm     <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            rx_error_q <= 1'b0;
`ifdef UART_HOST_RX_TIMEOUT_EN
            to_run     <= 1'b0;
            to_cnt     <= 24'd0;
`endif
        end else begin
            // Consumer handshake; a word loading this same cycle overrides below.
            if (m_tvalid_q && m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end
`ifdef UART_HOST_RX_TIMEOUT_EN
            if (to_run) begin
                if (to_cnt == to_lim_m1) begin
                    to_run     <= 1'b0;
                    rx_idx     <= '0;
                    rx_error_q <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 24'd1;
                end
            end
`endif
            case (rx_state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        rx_ps    <= ps_eff;
                        rx_cnt   <= half_m1;
                        rx_state <= ST_START;
`ifdef UART_HOST_RX_TIMEOUT_EN
                        to_run   <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (rx_cnt == 19'd0) begin
                        if (rxd_s) begin
                            rx_state <= ST_IDLE;   // glitch shorter than half a bit
`ifdef UART_HOST_RX_TIMEOUT_EN
                            to_run   <= (rx_idx != '0);
                            to_cnt   <= 24'd0;
`endif
                        end else begin
                            rx_cnt   <= rx_bit_m1;
                            rx_bit   <= 3'd0;
                            rx_state <= ST_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 19'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == 19'd0) begin
                        rx_shift <= {rxd_s, rx_shift[7:1]};
                        rx_cnt   <= rx_bit_m1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 19'd1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == 19'd0) begin
                        rx_state <= ST_IDLE;
                        if (rxd_s) begin
                            if (rx_idx == RXIW'(NB_RX - 1)) begin
                                rx_idx <= '0;
                                if (!m_tvalid_q || m_axis_tready) begin
                                    m_tdata_q  <= asm_next;
                                    m_tvalid_q <= 1'b1;
                                end else begin
                                    rx_error_q <= 1'b1;   // overrun: held word wins
                                end
                            end else begin
                                rx_asm <= asm_next;
                                rx_idx <= rx_idx + RXIW'(1);
`ifdef UART_HOST_RX_TIMEOUT_EN
                                to_run <= 1'b1;
                                to_cnt <= 24'd0;
`endif
                            end
                        end else begin
                            rx_idx     <= '0;
                            rx_error_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 19'd1;
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign rx_busy       = (rx_state != ST_IDLE);
    assign rx_error      = rx_error_q;

endmodule

// File: tb/tb_uart_host.sv
module tb_uart_host;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [15:0] s_axis_tdata = 16'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        rxd = 1'b1;
    logic        txd;
    logic [15:0] prescale = 16'd2;
    logic        tx_busy;
    logic        rx_busy;
    logic        rx_error;

    int checks = 0;
    int errors = 0;

    // Output-side monitor, sampled on the falling edge.
    int          hs_cnt = 0;
    logic [23:0] hs_data = 24'd0;
    int          vcyc = 0;
    int          busy_cnt = 0;

    always #5 clk = ~clk;

    uart_host #(.INP_WIDTH(16), .OUT_WIDTH(24)) dut (
        .clk          (clk),
        .arstn        (arstn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .rxd          (rxd),
        .txd          (txd),
        .prescale     (prescale),
        .tx_busy      (tx_busy),
        .rx_busy      (rx_busy),
        .rx_error     (rx_error)
    );

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            hs_cnt  = hs_cnt + 1;
            hs_data = m_axis_tdata;
        end
        if (m_axis_tvalid) vcyc = vcyc + 1;
        if (rx_busy) busy_cnt = busy_cnt + 1;
    end

    task automatic apply_reset();
        @(negedge clk);
        arstn = 1'b0;
        rxd = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One 8N1 frame at prescale=2 (16 cycles per bit), driven on falling edges.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (16) @(negedge clk);
        if (!stop_bit) begin
            rxd = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    // Sends one word and checks every bit of both frames at mid-bit, plus tready timing.
    task automatic tx_word_check(input logic [15:0] w, input string tag);
        logic [9:0] fr;
        @(negedge clk);
        s_axis_tdata = w;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = 16'hFFFF;
        checks++;
        if (s_axis_tready !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: tready=%b tx_busy=%b, required 0 and 1",
                     tag, s_axis_tready, tx_busy);
        end
        for (int b = 0; b < 2; b++) begin
            fr = {1'b1, w[b*8 +: 8], 1'b0};
            for (int k = 0; k < 10; k++) begin
                repeat (8) @(posedge clk);
                #1;
                checks++;
                if (txd !== fr[k]) begin
                    errors++;
                    $display("FAIL %s_txd byte%0d bit%0d: got %b, required %b",
                             tag, b, k, txd, fr[k]);
                end
                checks++;
                if (s_axis_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_tready_busy byte%0d bit%0d: got %b, required 0",
                             tag, b, k, s_axis_tready);
                end
                repeat (8) @(posedge clk);
            end
        end
        #1;
        checks++;
        if (s_axis_tready !== 1'b1 || tx_busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_at_320: tready=%b tx_busy=%b txd=%b, required 1 0 1",
                     tag, s_axis_tready, tx_busy, txd);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL reset_txd: got %b, required 1", txd);
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL reset_tready: got %b, required 1", s_axis_tready);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid: got %b, required 0", m_axis_tvalid);
        end
        checks++;
        if (m_axis_tdata !== 24'd0) begin
            errors++; $display("FAIL reset_tdata: got %h, required 000000", m_axis_tdata);
        end
        checks++;
        if (tx_busy !== 1'b0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: tx=%b rx=%b, required 0 0", tx_busy, rx_busy);
        end
        checks++;
        if (rx_error !== 1'b0) begin
            errors++; $display("FAIL reset_rx_error: got %b, required 0", rx_error);
        end
        @(negedge clk);
        arstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx_word();
        apply_reset();
        tx_word_check(16'hA55A, "tx_a55a");
    endtask

    task automatic test_rx_word();
        int hb, vb;
        apply_reset();
        hb = hs_cnt;
        vb = vcyc;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (hs_cnt - hb != 1) begin
            errors++; $display("FAIL rx_word_count: got %0d, required 1", hs_cnt - hb);
        end
        checks++;
        if (hs_data !== 24'h030201) begin
            errors++; $display("FAIL rx_word_data: got %h, required 030201", hs_data);
        end
        checks++;
        if (vcyc - vb != 1) begin
            errors++; $display("FAIL rx_word_tvalid_len: got %0d, required 1", vcyc - vb);
        end
        checks++;
        if (rx_error !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rx_word_after: rx_error=%b tvalid=%b, required 0 0",
                     rx_error, m_axis_tvalid);
        end
    endtask

    task automatic test_glitch();
        int hb, bb;
        apply_reset();
        hb = hs_cnt;
        bb = busy_cnt;
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (busy_cnt - bb != 8) begin
            errors++;
            $display("FAIL glitch_busy_cycles: got %0d, required 8", busy_cnt - bb);
        end
        checks++;
        if (rx_busy !== 1'b0 || hs_cnt - hb != 0) begin
            errors++;
            $display("FAIL glitch_idle: rx_busy=%b words=%0d, required 0 0",
                     rx_busy, hs_cnt - hb);
        end
        checks++;
        if (rx_error !== 1'b0) begin
            errors++; $display("FAIL glitch_rx_error: got %b, required 0", rx_error);
        end
    endtask

    task automatic test_frame_error();
        int hb;
        apply_reset();
        hb = hs_cnt;
        send_byte(8'h11, 1'b0);
        checks++;
        if (rx_error !== 1'b1) begin
            errors++; $display("FAIL frame_err_flag: got %b, required 1", rx_error);
        end
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (hs_cnt - hb != 1 || hs_data !== 24'hCCBBAA) begin
            errors++;
            $display("FAIL frame_err_word: count=%0d data=%h, required 1 CCBBAA",
                     hs_cnt - hb, hs_data);
        end
        checks++;
        if (rx_error !== 1'b1) begin
            errors++; $display("FAIL frame_err_sticky: got %b, required 1", rx_error);
        end
    endtask

    task automatic test_overrun();
        int hb;
        apply_reset();
        m_axis_tready = 1'b0;
        hb = hs_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h030201 || rx_error !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first: tvalid=%b data=%h err=%b, required 1 030201 0",
                     m_axis_tvalid, m_axis_tdata, rx_error);
        end
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h030201) begin
            errors++;
            $display("FAIL overrun_hold: tvalid=%b data=%h, required 1 030201",
                     m_axis_tvalid, m_axis_tdata);
        end
        checks++;
        if (rx_error !== 1'b1) begin
            errors++; $display("FAIL overrun_flag: got %b, required 1", rx_error);
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (hs_cnt - hb != 1 || hs_data !== 24'h030201 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drain: count=%0d data=%h tvalid=%b, required 1 030201 0",
                     hs_cnt - hb, hs_data, m_axis_tvalid);
        end
    endtask

    task automatic test_tx_reset();
        apply_reset();
        @(negedge clk);
        s_axis_tdata = 16'h12C5;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        // Middle of data bit 5 of byte 0 (0xC5 bit 5 = 0): 6.5 bit times after handshake.
        repeat (104) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL txrst_midbit: txd=%b tx_busy=%b, required 0 1", txd, tx_busy);
        end
        arstn = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || s_axis_tready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL txrst_abort: txd=%b tready=%b tx_busy=%b, required 1 1 0",
                     txd, s_axis_tready, tx_busy);
        end
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        repeat (2) @(negedge clk);
        tx_word_check(16'h3C81, "txrst_after");
    endtask

    initial begin
        test_reset();
        test_tx_word();
        test_rx_word();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_tx_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
